// File: rtl/rr_address_arbiter.sv
// ---------------------------------------------------------------------------
// rr_address_arbiter
//
// Round-robin arbiter placed in front of the 2-bit address decoder. It picks
// one of NREQ requesters, presents the winner's index on `address` qualified
// by `valid`, and holds the grant until the owner pulses `done` or drops its
// request. Each release is followed by at least one idle cycle, so the
// decoder enables never hop directly from one line to another.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a hold counter force-releases a grant after TIMEOUT cycles
//   and pulses `timeout` for one cycle. When undefined, no counter exists,
//   `timeout` is tied low and a grant is held until `done` or withdrawal.
//
// Ports:
//   clk      in   1     rising-edge clock
//   reset    in   1     synchronous active-high reset
//   req      in   NREQ  request lines, bit i = requester i
//   done     in   1     release pulse from the granted requester
//   address  out  AW    index of the granted requester
//   valid    out  1     high while `address` carries a live grant
//   ptr      out  AW    current highest-priority index
//   timeout  out  1     one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module rr_address_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [AW-1:0]   address,
    output logic            valid,
    output logic [AW-1:0]   ptr,
    output logic            timeout
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic          r_state;
    logic [AW-1:0] r_address;
    logic          r_valid;
    logic [AW-1:0] r_ptr;
    logic          r_timeout;

    logic [AW-1:0] w_winner;
    logic          w_anyReq;
    logic          w_userRelease;
    logic          w_forceRelease;

    // Elaboration-time guard: the scan relies on index arithmetic wrapping
    // naturally at AW bits, and the hold counter is 8 bits wide.
    if (NREQ != (1 << AW)) begin : g_badNreq
        $error("rr_address_arbiter: NREQ must equal 2**AW");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_badTimeout
        $error("rr_address_arbiter: TIMEOUT must be in 1..255");
    end

    // Scan from the highest offset down so that the set bit closest to ptr
    // (in wrap-around order) is the last one assigned and therefore wins.
    always_comb begin : winnerScan
        logic [AW-1:0] v_idx;
        w_winner = r_ptr;
        w_anyReq = 1'b0;
        v_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            v_idx = r_ptr + AW'(i);
            if (req[v_idx]) begin
                w_winner = v_idx;
                w_anyReq = 1'b1;
            end
        end
    end

    // Owner-driven release: explicit done, or the owner withdrew its request.
    assign w_userRelease = done | ~req[r_address];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] LP_HOLD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_holdCnt;

    // Counts cycles spent in GRANT; parked at zero while idle so every new
    // grant starts from a clean count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_holdCnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_holdCnt <= '0;
        end else begin
            r_holdCnt <= r_holdCnt + 8'd1;
        end
    end

    // A forced release only counts when no ordinary release is happening,
    // so `timeout` never pulses for a grant that ended normally.
    assign w_forceRelease = ~w_userRelease & (r_holdCnt == LP_HOLD_LAST);
`else
    assign w_forceRelease = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_address <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_address <= w_winner;
                        r_valid   <= 1'b1;
                        r_state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Release always returns to IDLE for at least one cycle,
                    // which guarantees the gap between consecutive grants.
                    if (w_userRelease || w_forceRelease) begin
                        r_valid   <= 1'b0;
                        r_ptr     <= r_address + AW'(1);
                        r_state   <= ST_IDLE;
                        r_timeout <= w_forceRelease;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign address = r_address;
    assign valid   = r_valid;
    assign ptr     = r_ptr;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_address_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_address_arbiter
//
// Self-checking bench for rr_address_arbiter. A behavioural model tracks who
// owns the grant, the priority pointer and any forced release; a negedge
// process compares every DUT output against it each cycle. Directed
// sequences with hand-computed literal expectations pin the model, then a
// randomized phase exercises requests, done pulses and occasional resets.
// Builds with or without ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_rr_address_arbiter;

    localparam int NREQ       = 4;
    localparam int AW         = 2;
    localparam int TB_TIMEOUT = 4;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic            done;
    logic [AW-1:0]   address;
    logic            valid;
    logic [AW-1:0]   ptr;
    logic            timeout;

    int nChecks;
    int nFails;
    bit checkEn;

    // Behavioural reference state
    bit mBusy;
    int mOwner;
    int mPtr;
    bit mTimeout;
    int mHeld;

    rr_address_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .address (address),
        .valid   (valid),
        .ptr     (ptr),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and log failures.
    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drive inputs, let one rising edge pass, then settle just after it.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic d, input logic rs);
        req   = r;
        done  = d;
        reset = rs;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a single owner at a time; a new owner is the first
    // requester met walking forward from the pointer; on release the pointer
    // moves to the slot just after the owner.
    always @(posedge clk) begin
        bit ownerLetGo;
        bit forced;
        if (reset) begin
            mBusy    = 0;
            mOwner   = 0;
            mPtr     = 0;
            mTimeout = 0;
            mHeld    = 0;
        end else begin
            mTimeout = 0;
            if (!mBusy) begin
                for (int k = 0; k < NREQ; k++) begin
                    int cand;
                    cand = (mPtr + k) % NREQ;
                    if (!mBusy && req[cand]) begin
                        mOwner = cand;
                        mBusy  = 1;
                        mHeld  = 1;
                    end
                end
            end else begin
                ownerLetGo = done || !req[mOwner];
                forced     = 0;
`ifdef ARB_TIMEOUT_EN
                if (!ownerLetGo && mHeld >= TB_TIMEOUT) forced = 1;
`endif
                if (ownerLetGo || forced) begin
                    mBusy    = 0;
                    mPtr     = (mOwner + 1) % NREQ;
                    mTimeout = forced;
                end else begin
                    mHeld++;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model.valid", int'(valid), int'(mBusy));
            checkOutput("model.address", int'(address), mOwner);
            checkOutput("model.ptr", int'(ptr), mPtr);
            checkOutput("model.timeout", int'(timeout), int'(mTimeout));
        end
    end

    initial begin
        int seqAddr;
        logic [NREQ-1:0] rndReq;
        nChecks = 0;
        nFails  = 0;
        checkEn = 0;
        req     = '0;
        done    = 1'b0;
        reset   = 1'b1;

        // Reset held two cycles with all requests active
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkEn = 1;
        checkOutput("reset.valid", int'(valid), 0);
        checkOutput("reset.address", int'(address), 0);
        checkOutput("reset.ptr", int'(ptr), 0);
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("reset2.valid", int'(valid), 0);
        checkOutput("reset2.ptr", int'(ptr), 0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("firstGrant.valid", int'(valid), 1);
        checkOutput("firstGrant.address", int'(address), 0);

        // Round robin 0,1,2,3,0 with done one cycle after each grant
        seqAddr = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0);
            checkOutput("rr.gapValid", int'(valid), 0);
            checkOutput("rr.ptr", int'(ptr), (seqAddr + 1) % 4);
            applyStimulus(4'b1111, 1'b0, 1'b0);
            seqAddr = (seqAddr + 1) % 4;
            checkOutput("rr.valid", int'(valid), 1);
            checkOutput("rr.address", int'(address), seqAddr);
        end

        // Move pointer to 3 via a grant on 2, then skip and wrap to 1
        applyStimulus(4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("skip.setupAddr", int'(address), 2);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("skip.ptrIs3", int'(ptr), 3);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("skip.address", int'(address), 1);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("skip.ptrAfter", int'(ptr), 2);

        // Withdrawal of requester 2 without done
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("withdraw.address", int'(address), 2);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("withdraw.valid", int'(valid), 0);
        checkOutput("withdraw.ptr", int'(ptr), 3);

        // done coinciding with a new request: gap first, then grant on 3
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("simul.firstAddr", int'(address), 0);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("simul.gapValid", int'(valid), 0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("simul.valid", int'(valid), 1);
        checkOutput("simul.address", int'(address), 3);
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Requester 2 holds forever without done
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("hold.address", int'(address), 2);
`ifdef ARB_TIMEOUT_EN
        checkOutput("hold.valid0", int'(valid), 1);
        for (int k = 1; k < TB_TIMEOUT; k++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0);
            checkOutput("hold.validN", int'(valid), 1);
        end
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("timeout.valid", int'(valid), 0);
        checkOutput("timeout.pulse", int'(timeout), 1);
        checkOutput("timeout.ptr", int'(ptr), 3);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("regrant.valid", int'(valid), 1);
        checkOutput("regrant.address", int'(address), 2);
        checkOutput("regrant.timeout", int'(timeout), 0);
`else
        for (int k = 0; k < 55; k++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0);
            checkOutput("hold.valid", int'(valid), 1);
            checkOutput("hold.timeout", int'(timeout), 0);
        end
`endif
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Randomized phase against the model
        rndReq = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3) rndReq = NREQ'($urandom_range(0, 15));
            applyStimulus(rndReq, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 149) == 0));
        end

        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/rr_address_arbiter.md
# rr_address_arbiter

Round-robin arbiter that sits directly upstream of the 2-bit address decoder. It selects one of four requesters, drives the winner's index on `address` with a `valid` qualifier, and holds the grant until the requester signals `done` or withdraws. The decoder consumes `address` and turns it into the one-hot `en[0:3]` bus. `valid` gates that bus so that no enable is active between grants.

## Interface
- `NREQ`, default 4: number of requesters; must equal 2**`AW`.
- `AW`, default 2: address width; matches the decoder `width`.
- `TIMEOUT`, default 16: maximum cycles a grant may be held; used only with `ARB_TIMEOUT_EN`; range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  in  NREQ  request lines; bit i = requester i.
- `done`  in  1  one-cycle pulse from the granted requester that releases the grant.
- `address`  out  AW  index of the granted requester; feeds decoder `address`.
- `valid`  out  1  high while `address` holds a live grant.
- `ptr`  out  AW  current highest-priority index (debug/observability).
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- States: IDLE, GRANT.
- Reset (priority over everything): state=IDLE, `address`=0, `valid`=0, `ptr`=0, `timeout`=0, hold counter=0.
- IDLE, `req`≠0:
  - Winner = first set bit of `req`, scanning `ptr`, `ptr`+1, … mod NREQ.
  - `address`←winner, `valid`←1, hold counter←0, go to GRANT.
- IDLE, `req`=0: stay; `valid`=0; `address` keeps its last value.
- GRANT: `address` stays stable. Release occurs when any of these holds:
  - `done`=1, or
  - `req[address]`=0 (requester withdrew), or
  - timeout (see Configuration).
- On release: `valid`←0, `ptr`←(`address`+1) mod NREQ (wraps 3→0), go to IDLE.
- `done` in IDLE is ignored.
- `req` bits other than the granted one are ignored during GRANT.
- `done` and a new request arriving together: the release happens first; the new request is arbitrated in the following IDLE cycle.
- Fairness: a requester that holds `req` continuously is served within NREQ grants.

## Timing
- Grant latency: `req` sampled high at edge k (state IDLE) → `valid`=1 and `address` valid after edge k.
- Release latency: `done` sampled at edge m → `valid`=0 after edge m.
- At least one cycle of `valid`=0 between consecutive grants. The decoder enables therefore never switch directly from one line to another.
- `ptr` updates on the same edge as the release.
- Reset asserted mid-grant: `valid`=0 after that edge. Any `done` sampled on the same edge is discarded.
- `timeout` is high for exactly the one cycle following the forced-release edge.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter increments every cycle in GRANT.
  - When the counter reaches `TIMEOUT`-1 and no other release condition holds, the grant is force-released: `valid`←0, `ptr` advances as normal, `timeout` pulses.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is instantiated.
  - `timeout` is tied to 0.
  - A grant is held indefinitely until `done` or withdrawal.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `req`=4'b1111 → `valid`=0, `address`=0, `ptr`=0 throughout. On release of reset, the first grant is `address`=0.
- Round-robin: `req`=4'b1111, pulse `done` one cycle after each grant → grants appear in the order 0,1,2,3,0. Each grant is separated by exactly one `valid`=0 cycle; `ptr` follows 1,2,3,0.
- Skip and wrap: `ptr`=3, `req`=4'b0010 → `address`=1. After `done`, `ptr`=2.
- Withdrawal: grant on 2, drop `req[2]` with no `done` → `valid`=0 on the next edge and `ptr`=3.
- Simultaneous: `done`=1 on the same cycle that `req` changes 4'b0001→4'b1000 → one cycle with `valid`=0, then `address`=3.
- Timeout (with `ARB_TIMEOUT_EN`, `TIMEOUT`=4): `req`=4'b0100 held, never `done` → `valid` high for 4 cycles, then a single `timeout` pulse with `valid`=0, then a re-grant of 2. Without the macro, `valid` stays high for 50+ cycles and `timeout`=0.
